// File: rtl/req_priority_encoder_pkg.sv
// Shared encodings and width helper for the registered request priority encoder.
package req_priority_encoder_pkg;

  localparam int unsigned PRIO_FIXED = 0;
  localparam int unsigned PRIO_RR    = 1;
  localparam int unsigned CAP_LEVEL  = 0;
  localparam int unsigned CAP_EDGE   = 1;

  // Index width for n request lines.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/req_priority_encoder_if.sv
// Request/grant bundle: capture inputs, valid/ready index output and status.
interface req_priority_encoder_if #(
  parameter int unsigned N = 16
);
  import req_priority_encoder_pkg::*;

  localparam int unsigned W = idx_width(N);

  logic         en;
  logic [N-1:0] req;
  logic [W-1:0] out_idx;
  logic         out_valid;
  logic         out_ready;
  logic         multi;
  logic [N-1:0] pending;

  modport master (
    output en, req, out_ready,
    input  out_idx, out_valid, multi, pending
  );

  modport slave (
    input  en, req, out_ready,
    output out_idx, out_valid, multi, pending
  );

endinterface

// File: rtl/req_priority_encoder_prio_pick_n.sv
// Combinational picker: first set bit searching downward from start, optional
// modulo-N wrap, plus a more-than-one-set flag.
module prio_pick_n
  import req_priority_encoder_pkg::*;
#(
  parameter int unsigned N    = 16,
  parameter int unsigned WRAP = 1
) (
  input  logic [N-1:0]              vec,
  input  logic [idx_width(N)-1:0]   start,
  output logic                      found,
  output logic [idx_width(N)-1:0]   idx,
  output logic                      multi
);

  localparam int unsigned W = idx_width(N);

  // Position visited at search step k.
  function automatic logic [W-1:0] pos_of(input logic [W-1:0] s, input int unsigned k);
    return W'((32'(s) + N - k) % N);
  endfunction

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!found && ((WRAP != 0) || (k <= 32'(start))) && vec[pos_of(start, k)]) begin
        found = 1'b1;
        idx   = pos_of(start, k);
      end
    end
    multi = ($countones(vec) > 1);
  end

endmodule

// File: rtl/req_priority_encoder.sv
// Registered N-way request priority encoder with pending capture, valid/ready
// grant handshake, fixed or round-robin priority and level or edge capture.
module req_priority_encoder
  import req_priority_encoder_pkg::*;
#(
  parameter int unsigned N         = 16,
  parameter int unsigned RR_MODE   = PRIO_FIXED,
  parameter int unsigned EDGE_MODE = CAP_LEVEL
) (
  input logic                  clk,
  input logic                  rst,
  req_priority_encoder_if.slave bus
);

  localparam int unsigned W = idx_width(N);

  logic [N-1:0] pending_q;
  logic [N-1:0] req_prev_q;
  logic [W-1:0] last_q;
  logic [W-1:0] out_idx_q;
  logic         out_valid_q;
  logic         multi_q;

  logic [N-1:0] cap_c;
  logic [N-1:0] clr_c;
  logic [N-1:0] sel_src_c;
  logic [W-1:0] start_c;
  logic         fire_c;
  logic         hold_c;
  logic         found_c;
  logic [W-1:0] pick_idx_c;
  logic         pick_multi_c;

  // Capture, grant clear and search start; selection sees pending minus this cycle's grant.
  always_comb begin
    cap_c     = (EDGE_MODE == CAP_EDGE) ? (bus.req & ~req_prev_q) : bus.req;
    fire_c    = out_valid_q & bus.out_ready;
    hold_c    = out_valid_q & ~bus.out_ready;
    clr_c     = fire_c ? (N'(1) << out_idx_q) : '0;
    sel_src_c = pending_q & ~clr_c;
    start_c   = W'(N - 1);
    if (RR_MODE == PRIO_RR) begin
      start_c = (last_q == '0) ? W'(N - 1) : (last_q - W'(1));
    end
  end

  prio_pick_n #(
    .N    (N),
    .WRAP ((RR_MODE == PRIO_RR) ? 1 : 0)
  ) u_pick (
    .vec   (sel_src_c),
    .start (start_c),
    .found (found_c),
    .idx   (pick_idx_c),
    .multi (pick_multi_c)
  );

  // New captures OR in after the clear, so a same-cycle re-request stays pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q   <= '0;
      req_prev_q  <= '0;
      last_q      <= '0;
      out_idx_q   <= '0;
      out_valid_q <= 1'b0;
      multi_q     <= 1'b0;
    end else begin
      req_prev_q <= bus.req;
      pending_q  <= sel_src_c | (bus.en ? cap_c : '0);
      if (fire_c) begin
        last_q <= out_idx_q;
      end
      if (!hold_c) begin
        out_valid_q <= found_c;
        out_idx_q   <= found_c ? pick_idx_c : '0;
        multi_q     <= pick_multi_c;
      end
    end
  end

  assign bus.out_idx   = out_idx_q;
  assign bus.out_valid = out_valid_q;
  assign bus.multi     = multi_q;
  assign bus.pending   = pending_q;

endmodule

// File: tb/tb_req_priority_encoder.sv
// Bench for req_priority_encoder: three configurations driven in lockstep and
// checked every cycle against a behavioural model, plus directed expectations.
module tb_req_priority_encoder;
  import req_priority_encoder_pkg::*;

  logic clk;
  logic rst;

  req_priority_encoder_if #(.N(16)) if_fix  ();
  req_priority_encoder_if #(.N(4))  if_rr   ();
  req_priority_encoder_if #(.N(16)) if_edge ();

  req_priority_encoder #(.N(16), .RR_MODE(PRIO_FIXED), .EDGE_MODE(CAP_LEVEL)) dut_fix (
    .clk(clk), .rst(rst), .bus(if_fix.slave));
  req_priority_encoder #(.N(4), .RR_MODE(PRIO_RR), .EDGE_MODE(CAP_LEVEL)) dut_rr (
    .clk(clk), .rst(rst), .bus(if_rr.slave));
  req_priority_encoder #(.N(16), .RR_MODE(PRIO_FIXED), .EDGE_MODE(CAP_EDGE)) dut_edge (
    .clk(clk), .rst(rst), .bus(if_edge.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Per-configuration model parameters: 0 fixed/level, 1 rr/level (N=4), 2 fixed/edge.
  int nn [3] = '{16, 4, 16};
  int rr [3] = '{0, 1, 0};
  int ed [3] = '{0, 0, 1};

  logic [15:0] m_pend [3];
  logic [15:0] m_prev [3];
  logic        m_val  [3];
  logic        m_mul  [3];
  int          m_idx  [3];
  int          m_last [3];

  logic [15:0] cur_req;
  logic        cur_en;
  logic        cur_rdy;

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s [dut%0d]: observed 0x%0h required 0x%0h", tag, d, obs, exp);
    end
  endtask

  task automatic mreset();
    for (int d = 0; d < 3; d++) begin
      m_pend[d] = '0; m_prev[d] = '0; m_val[d] = 1'b0;
      m_mul[d] = 1'b0; m_idx[d] = 0; m_last[d] = 0;
    end
  endtask

  // One clock edge of the reference behaviour for configuration d.
  task automatic mstep(input int d);
    int          n;
    int          cnt;
    int          start;
    int          pos;
    int          old_idx;
    logic        fire;
    logic [15:0] mask;
    logic [15:0] r;
    logic [15:0] clr;
    logic [15:0] src;
    logic [15:0] cap;
    n       = nn[d];
    mask    = 16'((32'(1) << n) - 1);
    r       = cur_req & mask;
    fire    = m_val[d] && cur_rdy;
    old_idx = m_idx[d];
    clr     = fire ? 16'(32'(1) << old_idx) : 16'h0;
    src     = m_pend[d] & ~clr;
    cap     = (ed[d] != 0) ? (r & ~m_prev[d]) : r;
    if (!(m_val[d] && !cur_rdy)) begin
      cnt      = $countones(src);
      m_val[d] = (cnt > 0);
      m_mul[d] = (cnt > 1);
      m_idx[d] = 0;
      start    = (rr[d] != 0) ? (m_last[d] + n - 1) % n : n - 1;
      for (int k = 0; k < n; k++) begin
        pos = (start - k + n) % n;
        if (src[pos]) begin
          m_idx[d] = pos;
          break;
        end
      end
    end
    if (fire) m_last[d] = old_idx;
    m_pend[d] = src | (cur_en ? cap : 16'h0);
    m_prev[d] = r;
  endtask

  task automatic check_all();
    logic [31:0] v, i, m, p;
    for (int d = 0; d < 3; d++) begin
      case (d)
        0: begin v = 32'(if_fix.out_valid);  i = 32'(if_fix.out_idx);  m = 32'(if_fix.multi);  p = 32'(if_fix.pending);  end
        1: begin v = 32'(if_rr.out_valid);   i = 32'(if_rr.out_idx);   m = 32'(if_rr.multi);   p = 32'(if_rr.pending);   end
        default: begin v = 32'(if_edge.out_valid); i = 32'(if_edge.out_idx); m = 32'(if_edge.multi); p = 32'(if_edge.pending); end
      endcase
      chk("model out_valid", d, v, 32'(m_val[d]));
      chk("model out_idx",   d, i, 32'(m_idx[d]));
      chk("model multi",     d, m, 32'(m_mul[d]));
      chk("model pending",   d, p, 32'(m_pend[d]));
    end
  endtask

  task automatic set_in(input logic [15:0] r, input logic e, input logic rdy);
    cur_req = r; cur_en = e; cur_rdy = rdy;
    if_fix.req  = r;      if_fix.en  = e; if_fix.out_ready  = rdy;
    if_rr.req   = r[3:0]; if_rr.en   = e; if_rr.out_ready   = rdy;
    if_edge.req = r;      if_edge.en = e; if_edge.out_ready = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    for (int d = 0; d < 3; d++) mstep(d);
    #1;
    check_all();
  endtask

  // Called 1ns after an edge; reset pulse stays clear of the next edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    mreset();
    check_all();
    rst = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int grants;
    rst = 1'b1;
    set_in(16'h0, 1'b1, 1'b1);
    mreset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("reset out_valid", 0, 32'(if_fix.out_valid), 0);
    chk("reset pending",   0, 32'(if_fix.pending), 0);
    rst = 1'b0;
    repeat (2) tick();

    // Single request: capture, present, clear.
    set_in(16'h0008, 1'b1, 1'b1);
    tick();
    chk("single pending", 0, 32'(if_fix.pending), 32'h8);
    chk("single valid t0", 0, 32'(if_fix.out_valid), 0);
    set_in(16'h0000, 1'b1, 1'b1);
    tick();
    chk("single valid", 0, 32'(if_fix.out_valid), 1);
    chk("single idx",   0, 32'(if_fix.out_idx), 3);
    chk("single multi", 0, 32'(if_fix.multi), 0);
    tick();
    chk("single drained", 0, 32'(if_fix.out_valid), 0);
    chk("single pend clr", 0, 32'(if_fix.pending), 0);

    // Three requests granted back to back in fixed priority.
    set_in(16'h8101, 1'b1, 1'b1);
    tick();
    set_in(16'h0000, 1'b1, 1'b1);
    tick();
    chk("burst idx0", 0, 32'(if_fix.out_idx), 15);
    chk("burst mul0", 0, 32'(if_fix.multi), 1);
    tick();
    chk("burst idx1", 0, 32'(if_fix.out_idx), 8);
    chk("burst mul1", 0, 32'(if_fix.multi), 1);
    tick();
    chk("burst valid2", 0, 32'(if_fix.out_valid), 1);
    chk("burst idx2", 0, 32'(if_fix.out_idx), 0);
    chk("burst mul2", 0, 32'(if_fix.multi), 0);
    tick();
    chk("burst empty", 0, 32'(if_fix.out_valid), 0);
    chk("burst pend", 0, 32'(if_fix.pending), 0);

    // Output holds while stalled even when a higher request arrives.
    set_in(16'h0010, 1'b1, 1'b0);
    tick();
    set_in(16'h0000, 1'b1, 1'b0);
    tick();
    chk("hold idx a", 0, 32'(if_fix.out_idx), 4);
    set_in(16'h4000, 1'b1, 1'b0);
    tick();
    set_in(16'h0000, 1'b1, 1'b0);
    tick();
    chk("hold idx b", 0, 32'(if_fix.out_idx), 4);
    chk("hold multi", 0, 32'(if_fix.multi), 0);
    chk("hold pend",  0, 32'(if_fix.pending), 32'h4010);
    set_in(16'h0000, 1'b1, 1'b1);
    tick();
    chk("hold next", 0, 32'(if_fix.out_idx), 14);
    tick();
    chk("hold empty", 0, 32'(if_fix.out_valid), 0);

    // Round-robin rotation with all four requests held.
    do_reset();
    set_in(16'h000F, 1'b1, 1'b1);
    tick();
    begin
      int exp_rr [6] = '{3, 2, 1, 0, 3, 2};
      for (int s = 0; s < 6; s++) begin
        tick();
        chk("rr valid", 1, 32'(if_rr.out_valid), 1);
        chk("rr idx",   1, 32'(if_rr.out_idx), 32'(exp_rr[s]));
      end
    end
    set_in(16'h0000, 1'b1, 1'b1);
    repeat (3) tick();

    // Edge capture: a held request is granted once; a rising edge with en low is lost.
    do_reset();
    grants = 0;
    set_in(16'h0020, 1'b1, 1'b1);
    for (int s = 0; s < 10; s++) begin
      tick();
      if (if_edge.out_valid) begin
        grants++;
        chk("edge idx", 2, 32'(if_edge.out_idx), 5);
      end
    end
    chk("edge grants", 2, 32'(grants), 1);
    set_in(16'h0000, 1'b1, 1'b1);
    tick();
    set_in(16'h0020, 1'b0, 1'b1);
    tick();
    grants = 0;
    set_in(16'h0020, 1'b1, 1'b1);
    for (int s = 0; s < 9; s++) begin
      tick();
      if (if_edge.out_valid) grants++;
    end
    chk("edge en-low grants", 2, 32'(grants), 0);
    chk("edge en-low pend",   2, 32'(if_edge.pending), 0);

    // Asynchronous reset while a grant is outstanding.
    do_reset();
    set_in(16'h0300, 1'b1, 1'b0);
    tick();
    set_in(16'h0000, 1'b1, 1'b0);
    tick();
    chk("arst pre valid", 0, 32'(if_fix.out_valid), 1);
    chk("arst pre idx",   0, 32'(if_fix.out_idx), 9);
    chk("arst pre pend",  0, 32'(if_fix.pending), 32'h0300);
    rst = 1'b1;
    #1;
    mreset();
    chk("arst valid", 0, 32'(if_fix.out_valid), 0);
    chk("arst idx",   0, 32'(if_fix.out_idx), 0);
    chk("arst multi", 0, 32'(if_fix.multi), 0);
    chk("arst pend",  0, 32'(if_fix.pending), 0);
    #1;
    rst = 1'b0;
    set_in(16'h0000, 1'b1, 1'b1);
    for (int s = 0; s < 3; s++) begin
      tick();
      chk("arst after", 0, 32'(if_fix.out_valid), 0);
    end

    // Random traffic against the model, with occasional resets.
    for (int s = 0; s < 300; s++) begin
      set_in(16'($urandom) & 16'($urandom), ($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 7));
      tick();
      if ((s % 97) == 96) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
